// File: rtl/wb_matrix_engine.sv
// wb_matrix_engine: Wishbone-slave engine computing C = A op B (MUL/ADD/SUB/HAD) over runtime MxKxN.
module wb_matrix_engine #(
  parameter int DW = 32,
  parameter int DIM = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wb_addr_i,
  input  logic          wb_we_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          wb_stb,
  output logic          wb_ack,
  output logic [DW-1:0] wb_data_o,
  output logic          irq_o
);
  localparam int IB = $clog2(DIM);
  typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [DW-1:0] a [DIM][DIM];
  logic [DW-1:0] b [DIM][DIM];
  logic [DW-1:0] c [DIM][DIM];
  logic [DW-1:0] op, m, k, n, acc, prod, res, rdata;
  logic [IB-1:0] ri, rj, rk, ai, aj;
  logic [2:0] sel;
  logic [1:0] space;
  logic irq_en, done, err, busy, req, wr, start, in_rng, legal, last_i, last_j, last_k;

  function automatic logic dim_ok(input logic [DW-1:0] d);
    return d != '0 && d <= DW'(DIM);
  endfunction

  assign req = wb_stb & ~wb_ack;
  assign space = wb_addr_i[23:22];
  assign sel = wb_addr_i[4:2];
  assign ai = wb_addr_i[2*IB-1:IB];
  assign aj = wb_addr_i[IB-1:0];
  assign in_rng = int'(ai) < DIM && int'(aj) < DIM;
  // Configuration and operand writes are only accepted while the engine is idle
  assign wr = req && wb_we_i && state == IDLE;
  assign start = wr && space == 2'd0 && sel == 3'd4 && wb_data_i[0];
  assign legal = op >= DW'(1) && op <= DW'(4) && dim_ok(m) && dim_ok(n) && (op != DW'(1) || dim_ok(k));
  assign last_k = op != DW'(1) || DW'(rk) == k - DW'(1);
  assign last_j = DW'(rj) == n - DW'(1);
  assign last_i = DW'(ri) == m - DW'(1);
  assign irq_o = done & irq_en;
  assign prod = a[ri][rk] * b[rk][rj];
  assign res = op == DW'(1) ? acc + prod :
               op == DW'(2) ? a[ri][rj] + b[ri][rj] :
               op == DW'(3) ? a[ri][rj] - b[ri][rj] : a[ri][rj] * b[ri][rj];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_nx;

  always_comb
    state_nx = state == IDLE  ? (start ? CHECK : IDLE) :
               state == CHECK ? (legal ? RUN : FIN) :
               state == RUN   ? (last_i && last_j && last_k ? FIN : RUN) : IDLE;

  always_comb busy = state == RUN;

  always_comb begin
    rdata = '0;
    if (space == 2'd0)
      rdata = sel == 3'd0 ? op : sel == 3'd1 ? m : sel == 3'd2 ? k : sel == 3'd3 ? n :
              sel == 3'd4 ? DW'({irq_en, 1'b0}) : sel == 3'd5 ? DW'({err, done, busy}) : '0;
    else if (in_rng)
      rdata = space == 2'd1 ? a[ai][aj] : space == 2'd2 ? b[ai][aj] :
              state == IDLE ? c[ai][aj] : '0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wb_ack <= 1'b0;
      wb_data_o <= '0;
      {op, m, k, n, acc} <= '0;
      {ri, rj, rk} <= '0;
      {irq_en, done, err} <= '0;
      for (int x = 0; x < DIM; x++)
        for (int y = 0; y < DIM; y++) begin
          a[x][y] <= '0;
          b[x][y] <= '0;
          c[x][y] <= '0;
        end
    end else begin
      wb_ack <= req;
      wb_data_o <= req ? rdata : '0;
      if (wr && space == 2'd0) begin
        if (sel == 3'd0) op <= wb_data_i;
        if (sel == 3'd1) m <= wb_data_i;
        if (sel == 3'd2) k <= wb_data_i;
        if (sel == 3'd3) n <= wb_data_i;
        if (sel == 3'd4) irq_en <= wb_data_i[1];
      end
      if (wr && in_rng && space == 2'd1) a[ai][aj] <= wb_data_i;
      if (wr && in_rng && space == 2'd2) b[ai][aj] <= wb_data_i;
      if ((req && wb_we_i && space == 2'd0 && sel == 3'd5 && wb_data_i[1]) || start) begin
        done <= 1'b0;
        err <= 1'b0;
      end
      if (state == CHECK) begin
        {ri, rj, rk} <= '0;
        acc <= '0;
        err <= ~legal;
      end
      if (state == FIN) done <= 1'b1;
      if (busy) begin
        acc <= last_k ? '0 : acc + prod;
        rk <= last_k ? '0 : rk + 1'b1;
        if (last_k) begin
          c[ri][rj] <= res;
          rj <= last_j ? '0 : rj + 1'b1;
          if (last_j) ri <= ri + 1'b1;
        end
      end
    end
endmodule
